cpu_run_ctrl: RTL

//  Parametrised run/step/breakpoint controller for the single-cycle CPU.
//  - Sequences the CPU reset and gates PCWre.
//  - Counts cycles and retired instructions.
//  - Stops the CPU on a halt opcode, a PC breakpoint or a user request.
//  - Sits between the top-level CLK/Reset and the CPU core; replaces free-running bench clocking for board bring-up.

---
 rtl/cpu_run_ctrl_pkg.sv | 36 +++
 rtl/cpu_run_ctrl_if.sv | 39 +++
 rtl/cpu_run_ctrl_bp_match.sv | 60 ++++++
 rtl/cpu_run_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run/step/breakpoint controller:
// controller state codes, stop-cause codes and the default halt opcode.
package cpu_run_ctrl_pkg;

  // Controller state, encoded exactly as presented on the state output.
  typedef enum logic [2:0] {
    ST_HOLD = 3'd0,
    ST_IDLE = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_STOP = 3'd4
  } run_state_e;

  // Reason for the most recent stop, encoded as presented on stop_cause.
  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_USER = 2'd1,
    CAUSE_BP   = 2'd2,
    CAUSE_HALT = 2'd3
  } stop_cause_e;

  localparam logic [5:0] HALT_OP_DEFAULT = 6'b111111;

  // True in the states where the CPU is allowed to advance.
  function automatic logic is_active(input run_state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

  // Stop-cause priority: halt opcode over breakpoint over user/step.
  function automatic stop_cause_e pick_cause(input logic halt_hit, input logic bp_hit);
    if (halt_hit)    return CAUSE_HALT;
    else if (bp_hit) return CAUSE_BP;
    else             return CAUSE_USER;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Debug-side bus of the run controller: requests, breakpoint programming,
// CPU observation inputs and controller status outputs.
interface cpu_run_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CYC_W = 32
);
  logic              run_req;
  logic              step_req;
  logic              halt_req;
  logic              bp_wr_en;
  logic [3:0]        bp_wr_idx;
  logic              bp_wr_valid;
  logic [PC_W-1:0]   bp_wr_addr;
  logic [PC_W-1:0]   PCout;
  logic [5:0]        op;
  logic              cpu_rst_n;
  logic              PCWre;
  logic [2:0]        state;
  logic [1:0]        stop_cause;
  logic [3:0]        bp_hit_idx;
  logic [CYC_W-1:0]  cycle_cnt;
  logic [CYC_W-1:0]  instr_cnt;

  // Debugger / CPU side: drives requests and CPU observations.
  modport master (
    output run_req, step_req, halt_req,
    output bp_wr_en, bp_wr_idx, bp_wr_valid, bp_wr_addr,
    output PCout, op,
    input  cpu_rst_n, PCWre, state, stop_cause, bp_hit_idx, cycle_cnt, instr_cnt
  );

  // Controller side.
  modport slave (
    input  run_req, step_req, halt_req,
    input  bp_wr_en, bp_wr_idx, bp_wr_valid, bp_wr_addr,
    input  PCout, op,
    output cpu_rst_n, PCWre, state, stop_cause, bp_hit_idx, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/cpu_run_ctrl_bp_match.sv
// Breakpoint slots: NUM_BP armed/address registers with PC comparators.
// Reports whether any armed slot matches the PC and the lowest such slot.
module cpu_run_ctrl_bp_match #(
  parameter int PC_W   = 32,
  parameter int NUM_BP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [3:0]      wr_idx,
  input  logic            wr_valid,
  input  logic [PC_W-1:0] wr_addr,
  input  logic [PC_W-1:0] pc,
  input  logic            mask,
  output logic            match,
  output logic [3:0]      match_idx
);

  logic [NUM_BP-1:0] armed_q;
  logic [PC_W-1:0]   addr_q [NUM_BP];
  logic              any_hit;

  // Arm/disarm slots; indices beyond NUM_BP never compare equal, so they are dropped.
  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (wr_idx == 4'(i)) armed_q[i] <= wr_valid;
      end
    end
  end

  // Capture slot addresses.
  // NOTE: the address array has no reset; a slot's address is ignored until its armed bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (wr_idx == 4'(i)) addr_q[i] <= wr_addr;
      end
    end
  end

  // Compare every armed slot; scanning downward leaves the lowest match index.
  // NOTE: defaults are assigned first so no path through this block infers a latch.
  always_comb begin
    any_hit   = 1'b0;
    match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (armed_q[i] && (addr_q[i] == pc)) begin
        any_hit   = 1'b1;
        match_idx = 4'(i);
      end
    end
  end

  assign match = any_hit & ~mask;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller for the single-cycle CPU: sequences the
// CPU reset, gates PCWre, counts cycles/instructions and stops on halt
// opcode, breakpoint or user request.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int         PC_W     = 32,
  parameter int         NUM_BP   = 4,
  parameter int         CYC_W    = 32,
  parameter logic [5:0] HALT_OP  = HALT_OP_DEFAULT,
  parameter int         RST_HOLD = 2
) (
  input logic           CLK,
  input logic           Reset,
  cpu_run_ctrl_if.slave bus
);

  localparam int               HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  run_state_e        state_q, state_d;
  stop_cause_e       cause_q, cause_d;
  logic [3:0]        hit_q, hit_d;
  logic              skip_q, skip_d;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [CYC_W-1:0]  cyc_q, ins_q;
  logic              cpu_rst_q;

  logic              bp_match;
  logic [3:0]        bp_idx;
  logic              halt_op;
  logic              active;
  logic              pcwre;

  cpu_run_ctrl_bp_match #(
    .PC_W   (PC_W),
    .NUM_BP (NUM_BP)
  ) u_bp (
    .clk       (CLK),
    .rst_n     (Reset),
    .wr_en     (bus.bp_wr_en),
    .wr_idx    (bus.bp_wr_idx),
    .wr_valid  (bus.bp_wr_valid),
    .wr_addr   (bus.bp_wr_addr),
    .pc        (bus.PCout),
    .mask      (skip_q),
    .match     (bp_match),
    .match_idx (bp_idx)
  );

  // The stopping instruction is suppressed in the same cycle it is seen.
  assign halt_op = (bus.op == HALT_OP);
  assign active  = is_active(state_q);
  assign pcwre   = active & ~halt_op & ~bp_match;

  // Next-state, stop-cause capture and breakpoint-skip control.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    hit_d   = hit_q;
    skip_d  = skip_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = ST_IDLE;
      end
      ST_IDLE, ST_STOP: begin
        // A halt-opcode stop is terminal until Reset.
        if (!(state_q == ST_STOP && cause_q == CAUSE_HALT) && (bus.run_req || bus.step_req)) begin
          state_d = bus.run_req ? ST_RUN : ST_STEP;
          // Resuming from a breakpoint must not re-hit the same PC.
          if (state_q == ST_STOP && cause_q == CAUSE_BP) skip_d = 1'b1;
        end
      end
      ST_RUN, ST_STEP: begin
        skip_d = 1'b0;
        if (state_q == ST_STEP || halt_op || bp_match || bus.halt_req) begin
          state_d = ST_STOP;
          cause_d = pick_cause(halt_op, bp_match);
          if (bp_match && !halt_op) hit_d = bp_idx;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // Controller state registers; cpu_rst_n follows the state leaving HOLD.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_HOLD;
      cause_q   <= CAUSE_NONE;
      hit_q     <= '0;
      skip_q    <= 1'b0;
      cpu_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      hit_q     <= hit_d;
      skip_q    <= skip_d;
      cpu_rst_q <= (state_d != ST_HOLD);
    end
  end

  // Count the cycles spent holding the CPU in reset after Reset release.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      hold_cnt_q <= '0;
    end else if (state_q == ST_HOLD && hold_cnt_q != HOLD_LAST) begin
      hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
    end
  end

  // Saturating cycle and retired-instruction counters.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (active && cyc_q != '1) cyc_q <= cyc_q + CYC_W'(1);
      if (pcwre && ins_q != '1)  ins_q <= ins_q + CYC_W'(1);
    end
  end

  assign bus.cpu_rst_n  = cpu_rst_q;
  assign bus.PCWre      = pcwre;
  assign bus.state      = state_q;
  assign bus.stop_cause = cause_q;
  assign bus.bp_hit_idx = hit_q;
  assign bus.cycle_cnt  = cyc_q;
  assign bus.instr_cnt  = ins_q;

endmodule
